csr_file: RTL
=============

# csr_file

Control/status register file for the LoongArch pipeline. It is the responder to the write-back stage's CSR port and exception report. It services CSR reads and masked writes, records exception state on `wb_ex`, and restores state on `ertn_flush`. It also runs the constant timer and drives the exception entry address, the return address and the interrupt-pending flag back into the pipeline.

## Interface
Parameters:
- `TIMER_W`, default 32, width of timer counter (TCFG.InitVal is `TIMER_W-2` bits).

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `csr_re` in 1: read strobe. Informational only; reads have no side effects.
- `csr_num` in 14: CSR address, shared by read and write.
- `csr_we` in 1: write strobe.
- `csr_wmask` in 32: per-bit write enable.
- `csr_wvalue` in 32: write data.
- `csr_rvalue` out 32: combinational read data for `csr_num`.
- `wb_ex` in 1: exception commit from write-back. Includes ertn.
- `wb_ecode` in 6: exception code.
- `wb_esubcode` in 9: exception subcode.
- `wb_pc` in 32: PC of the faulting instruction.
- `wb_vaddr` in 32: faulting data address.
- `ertn_flush` in 1: ertn commit.
- `hw_int_in` in 8: level hardware interrupts.
- `ipi_int_in` in 1: inter-processor interrupt.
- `has_int` out 1: enabled interrupt pending.
- `ex_entry` out 32: EENTRY value.
- `ertn_era` out 32: ERA value.

## Operation
- Masked write: `new = (old & ~wmask) | (wvalue & wmask)`, then the field writability mask below is applied.
- Writes are ignored in any cycle where `wb_ex` or `ertn_flush` is high.
- Registers (address: reset value, writable bits):
  - CRMD 0x0: 0x8. Bits [8:0] writable (PLV[1:0], IE[2], DA[3]).
  - PRMD 0x1: 0. Bits [2:0] writable (PPLV, PIE).
  - ECFG 0x4: 0. LIE bits [12:0] writable except bit 10 (mask 0x1BFF).
  - ESTAT 0x5: 0. Only IS[1:0] is software-writable.
    - IS[9:2] = `hw_int_in`, sampled every cycle.
    - IS[11] = timer interrupt.
    - IS[12] = `ipi_int_in`.
    - Ecode[21:16] and EsubCode[30:22] are hardware-written only.
  - ERA 0x6, BADV 0x7: 0, fully writable.
  - EENTRY 0xC: 0. Bits [31:6] writable, bits [5:0] read 0.
  - SAVE0–3 0x30–0x33: 0, fully writable.
  - TID 0x40: 0, fully writable.
  - TCFG 0x41: 0. En[0], Periodic[1], InitVal[31:2].
  - TVAL 0x42: read-only, returns the counter value.
  - TICLR 0x44: reads 0. Writing 1 to bit 0 clears IS[11].
- Unimplemented addresses read 0; writes to them are dropped.
- Exception (`wb_ex` high and `ertn_flush` low), applied in one clock:
  - PRMD.PPLV ← CRMD.PLV; PRMD.PIE ← CRMD.IE.
  - CRMD.PLV ← 0; CRMD.IE ← 0.
  - ESTAT.Ecode/EsubCode ← inputs.
  - ERA ← `wb_pc`.
  - BADV ← `wb_pc` if ecode is 0x08 (ADEF), ← `wb_vaddr` if ecode is 0x09 (ALE), otherwise unchanged.
- `ertn_flush` high: CRMD.PLV ← PRMD.PPLV; CRMD.IE ← PRMD.PIE. `ertn_flush` has priority over `wb_ex`.
- Timer counter:
  - TCFG write with resulting En=1: counter ← {InitVal,2'b00}.
  - Otherwise, when En=1 and the counter is 0: IS[11] ← 1; counter ← Periodic ? {InitVal,2'b00} : all-ones (stopped).
  - Otherwise, when En=1 and the counter is not all-ones: counter decrements by 1.
- Simultaneous events:
  - TICLR clear and timer expiry in the same cycle: the set wins.
  - TCFG write and expiry in the same cycle: IS[11] is set and the counter takes the written value.
- `has_int = CRMD.IE & |(ESTAT.IS[12:0] & ECFG.LIE[12:0])`.

## Timing
- `csr_rvalue`, `has_int`, `ex_entry` and `ertn_era` are combinational from register state. A read in the same cycle as a write returns the old value.
- Every state update commits at the next posedge, so the write-to-read latency is 1 cycle.
- Interrupt inputs reach IS, and therefore `has_int`, 1 cycle after they are applied.
- Timer: a TCFG write at cycle N with InitVal=k, En=1 gives TVAL = 4k at N+1, TVAL = 0 at N+1+4k, and IS[11] = 1 at N+2+4k.
- `reset` asserted at any time returns every register to its reset value at the next edge, including a mid-count timer.
- Output reset values: `csr_rvalue` = value of the addressed CSR (CRMD reads 0x8), `has_int` = 0, `ex_entry` = 0, `ertn_era` = 0.

## Configuration
- `CSR_TIMER_EN` defined: TID, TCFG, TVAL and TICLR are implemented as above.
- `CSR_TIMER_EN` undefined:
  - Those four addresses read 0 and ignore writes.
  - IS[11] is constant 0.
  - `csr_timer` is not instantiated.

## Structure
- Shared package `csr_pkg` holds:
  - the CSR address localparams (CSR_CRMD … CSR_TICLR);
  - the ecode constants (ECODE_INT 0x00, ADEF 0x08, ALE 0x09, SYS 0x0B, BRK 0x0C, INE 0x0D);
  - the field write masks.
- One sub-module, `csr_timer`, owns:
  - the counter and reload/expiry logic;
  - its outputs: the counter value and a 1-cycle `timer_fire` pulse.
- `csr_file` owns IS[11] set/clear.

## Test plan
- Reset, then read 0x0 -> 0x00000008. Read 0x5 -> 0. `has_int` = 0.
- Write SAVE1 with value 0xDEADBEEF, mask 0xFFFF0000 -> reads 0xDEAD0000. A same-cycle read returns 0.
- Set CRMD=0x7, then `wb_ex` with ecode 0x09, `wb_pc`=0x1C000100, `wb_vaddr`=0x3 ->
  - CRMD[2:0]=0, PRMD[2:0]=0x7;
  - ERA=0x1C000100, BADV=0x3, ESTAT[21:16]=0x09.
  - Then `ertn_flush` -> CRMD[2:0]=0x7.
- Exception and `csr_we` to SAVE0 in the same cycle -> SAVE0 unchanged. `ertn_flush` and `wb_ex` in the same cycle -> only the ertn effect occurs.
- Write TCFG=0x0000000B (InitVal=2, periodic, en) ->
  - TVAL counts 8…0, IS[11] is set, TVAL reloads to 8;
  - with LIE[11]=1 and IE=1, `has_int`=1;
  - TICLR write of 1 -> IS[11]=0 next cycle.
- `hw_int_in`=0x01 with LIE[2]=1 and IE=1 -> `has_int` goes to 1 one cycle later. Without `CSR_TIMER_EN`, a read of TVAL -> 0.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared CSR address map, exception codes and field write masks for csr_file.
package csr_pkg;

  localparam logic [13:0] CSR_CRMD   = 14'h000;
  localparam logic [13:0] CSR_PRMD   = 14'h001;
  localparam logic [13:0] CSR_ECFG   = 14'h004;
  localparam logic [13:0] CSR_ESTAT  = 14'h005;
  localparam logic [13:0] CSR_ERA    = 14'h006;
  localparam logic [13:0] CSR_BADV   = 14'h007;
  localparam logic [13:0] CSR_EENTRY = 14'h00C;
  localparam logic [13:0] CSR_SAVE0  = 14'h030;
  localparam logic [13:0] CSR_SAVE1  = 14'h031;
  localparam logic [13:0] CSR_SAVE2  = 14'h032;
  localparam logic [13:0] CSR_SAVE3  = 14'h033;
  localparam logic [13:0] CSR_TID    = 14'h040;
  localparam logic [13:0] CSR_TCFG   = 14'h041;
  localparam logic [13:0] CSR_TVAL   = 14'h042;
  localparam logic [13:0] CSR_TICLR  = 14'h044;

  typedef enum logic [5:0] {
    ECODE_INT  = 6'h00,
    ECODE_ADEF = 6'h08,
    ECODE_ALE  = 6'h09,
    ECODE_SYS  = 6'h0B,
    ECODE_BRK  = 6'h0C,
    ECODE_INE  = 6'h0D
  } ecode_e;

  localparam logic [31:0] MASK_CRMD   = 32'h0000_01FF;
  localparam logic [31:0] MASK_PRMD   = 32'h0000_0007;
  localparam logic [31:0] MASK_ECFG   = 32'h0000_1BFF;
  localparam logic [31:0] MASK_ESTAT  = 32'h0000_0003;
  localparam logic [31:0] MASK_EENTRY = 32'hFFFF_FFC0;

  function automatic logic [31:0] masked_merge(input logic [31:0] old_v,
                                               input logic [31:0] wmask,
                                               input logic [31:0] wvalue);
    return (old_v & ~wmask) | (wvalue & wmask);
  endfunction

endpackage

// File: rtl/csr_file_if.sv
// Write-back stage <-> CSR file port: CSR access, exception report and returned state.
interface csr_file_if;
  logic        csr_re;
  logic [13:0] csr_num;
  logic        csr_we;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  logic [31:0] csr_rvalue;
  logic        wb_ex;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc;
  logic [31:0] wb_vaddr;
  logic        ertn_flush;
  logic        has_int;
  logic [31:0] ex_entry;
  logic [31:0] ertn_era;

  modport master (
    output csr_re, csr_num, csr_we, csr_wmask, csr_wvalue,
    output wb_ex, wb_ecode, wb_esubcode, wb_pc, wb_vaddr, ertn_flush,
    input  csr_rvalue, has_int, ex_entry, ertn_era
  );

  modport slave (
    input  csr_re, csr_num, csr_we, csr_wmask, csr_wvalue,
    input  wb_ex, wb_ecode, wb_esubcode, wb_pc, wb_vaddr, ertn_flush,
    output csr_rvalue, has_int, ex_entry, ertn_era
  );
endinterface

// File: rtl/csr_timer.sv
// Constant timer: reload on an enabling TCFG write, count down, pulse timer_fire at zero.
module csr_timer #(
  parameter int TIMER_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        i_tcfg,
  input  logic               i_tcfg_we,
  input  logic [31:0]        i_tcfg_wdata,
  output logic [TIMER_W-1:0] o_tval,
  output logic               o_timer_fire
);
  localparam logic [TIMER_W-1:0] ALL_ONES = '1;

  logic [TIMER_W-1:0] r_cnt;
  logic [TIMER_W-1:0] w_reload;
  logic [TIMER_W-1:0] w_load_new;
  logic               w_en;
  logic               w_periodic;
  logic               w_unused_ok;

  assign w_en         = i_tcfg[0];
  assign w_periodic   = i_tcfg[1];
  assign w_reload     = {i_tcfg[TIMER_W-1:2], 2'b00};
  assign w_load_new   = {i_tcfg_wdata[TIMER_W-1:2], 2'b00};
  assign w_unused_ok  = i_tcfg_wdata[1];
  assign o_timer_fire = w_en && (r_cnt == '0);
  assign o_tval       = r_cnt;

  // All-ones is the parked value of a one-shot timer that has expired.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_tcfg_we && i_tcfg_wdata[0]) begin
      r_cnt <= w_load_new;
    end else if (o_timer_fire) begin
      r_cnt <= w_periodic ? w_reload : ALL_ONES;
    end else if (w_en && (r_cnt != ALL_ONES)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end
endmodule

// File: rtl/csr_file.sv
// LoongArch CSR file: masked CSR writes, exception/ertn state, interrupts, entry/return address.
// Timer CSRs (TID/TCFG/TVAL/TICLR) and csr_timer exist only when CSR_TIMER_EN is defined.
module csr_file
  import csr_pkg::*;
#(
  parameter int TIMER_W = 32
) (
  input  logic       clk,
  input  logic       reset,
  csr_file_if.slave  bus,
  input  logic [7:0] hw_int_in,
  input  logic       ipi_int_in
);
  logic [8:0]  r_crmd;
  logic [2:0]  r_prmd;
  logic [12:0] r_ecfg;
  logic [1:0]  r_is_sw;
  logic [7:0]  r_is_hw;
  logic        r_is_ipi;
  logic [5:0]  r_ecode;
  logic [8:0]  r_esubcode;
  logic [31:0] r_era;
  logic [31:0] r_badv;
  logic [25:0] r_eentry;
  logic [31:0] w_save [4];
  logic        w_is_ti;
  logic [12:0] w_is;
  logic [31:0] w_estat;
  logic [31:0] w_rdata;
  logic [31:0] w_wnew;
  logic        w_we;
  logic        w_ex;
  logic        w_unused_ok;

  assign w_we        = bus.csr_we & ~bus.wb_ex & ~bus.ertn_flush;
  assign w_ex        = bus.wb_ex & ~bus.ertn_flush;
  assign w_wnew      = masked_merge(w_rdata, bus.csr_wmask, bus.csr_wvalue);
  assign w_is        = {r_is_ipi, w_is_ti, 1'b0, r_is_hw, r_is_sw};
  assign w_estat     = {1'b0, r_esubcode, r_ecode, 3'b000, w_is};
  assign w_unused_ok = bus.csr_re;

  assign bus.csr_rvalue = w_rdata;
  assign bus.has_int    = r_crmd[2] & (|(w_is & r_ecfg));
  assign bus.ex_entry   = {r_eentry, 6'b000000};
  assign bus.ertn_era   = r_era;

`ifdef CSR_TIMER_EN
  logic [31:0]        r_tid;
  logic [31:0]        r_tcfg;
  logic               r_is_ti;
  logic [TIMER_W-1:0] w_tval;
  logic               w_timer_fire;
  logic               w_tcfg_we;

  assign w_tcfg_we = w_we && (bus.csr_num == CSR_TCFG);
  assign w_is_ti   = r_is_ti;

  csr_timer #(.TIMER_W(TIMER_W)) u_timer (
    .clk          (clk),
    .reset        (reset),
    .i_tcfg       (r_tcfg),
    .i_tcfg_we    (w_tcfg_we),
    .i_tcfg_wdata (w_wnew),
    .o_tval       (w_tval),
    .o_timer_fire (w_timer_fire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tid   <= '0;
      r_tcfg  <= '0;
      r_is_ti <= 1'b0;
    end else begin
      if (w_we && (bus.csr_num == CSR_TID)) r_tid <= w_wnew;
      if (w_tcfg_we) r_tcfg <= w_wnew;
      // Expiry beats a same-cycle TICLR so no timer interrupt is lost.
      if (w_timer_fire) r_is_ti <= 1'b1;
      else if (w_we && (bus.csr_num == CSR_TICLR) && w_wnew[0]) r_is_ti <= 1'b0;
    end
  end
`else
  localparam int UNUSED_TIMER_W = TIMER_W;
  assign w_is_ti = 1'b0;
`endif

  always_comb begin
    w_rdata = '0;
    case (bus.csr_num)
      CSR_CRMD:   w_rdata = {23'b0, r_crmd};
      CSR_PRMD:   w_rdata = {29'b0, r_prmd};
      CSR_ECFG:   w_rdata = {19'b0, r_ecfg};
      CSR_ESTAT:  w_rdata = w_estat;
      CSR_ERA:    w_rdata = r_era;
      CSR_BADV:   w_rdata = r_badv;
      CSR_EENTRY: w_rdata = {r_eentry, 6'b000000};
      CSR_SAVE0:  w_rdata = w_save[0];
      CSR_SAVE1:  w_rdata = w_save[1];
      CSR_SAVE2:  w_rdata = w_save[2];
      CSR_SAVE3:  w_rdata = w_save[3];
`ifdef CSR_TIMER_EN
      CSR_TID:    w_rdata = r_tid;
      CSR_TCFG:   w_rdata = r_tcfg;
      CSR_TVAL:   w_rdata = 32'(w_tval);
`endif
      default:    w_rdata = '0;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_save
      logic [31:0] r_save;
      always_ff @(posedge clk) begin
        if (reset) r_save <= '0;
        else if (w_we && (bus.csr_num == CSR_SAVE0 + 14'(gi))) r_save <= w_wnew;
      end
      assign w_save[gi] = r_save;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_crmd     <= 9'h008;
      r_prmd     <= '0;
      r_ecfg     <= '0;
      r_is_sw    <= '0;
      r_is_hw    <= '0;
      r_is_ipi   <= 1'b0;
      r_ecode    <= '0;
      r_esubcode <= '0;
      r_era      <= '0;
      r_badv     <= '0;
      r_eentry   <= '0;
    end else begin
      r_is_hw  <= hw_int_in;
      r_is_ipi <= ipi_int_in;
      if (bus.ertn_flush) begin
        r_crmd[2:0] <= r_prmd;
      end else if (w_ex) begin
        r_prmd      <= r_crmd[2:0];
        r_crmd[2:0] <= 3'b000;
        r_ecode     <= bus.wb_ecode;
        r_esubcode  <= bus.wb_esubcode;
        r_era       <= bus.wb_pc;
        if (bus.wb_ecode == ECODE_ADEF) r_badv <= bus.wb_pc;
        else if (bus.wb_ecode == ECODE_ALE) r_badv <= bus.wb_vaddr;
      end else if (w_we) begin
        case (bus.csr_num)
          CSR_CRMD:   r_crmd   <= w_wnew[8:0] & MASK_CRMD[8:0];
          CSR_PRMD:   r_prmd   <= w_wnew[2:0] & MASK_PRMD[2:0];
          CSR_ECFG:   r_ecfg   <= w_wnew[12:0] & MASK_ECFG[12:0];
          CSR_ESTAT:  r_is_sw  <= w_wnew[1:0] & MASK_ESTAT[1:0];
          CSR_ERA:    r_era    <= w_wnew;
          CSR_BADV:   r_badv   <= w_wnew;
          CSR_EENTRY: r_eentry <= w_wnew[31:6] & MASK_EENTRY[31:6];
          default: ;
        endcase
      end
    end
  end
endmodule
